// File: rtl/ecc_pkg.sv
// Shared types and constants for the secp256k1 scalar-multiply control path.
package ecc_pkg;

  localparam int unsigned W_DEF  = 256;
  localparam int unsigned KW_DEF = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DBL_REQ,
    ST_DBL_WAIT,
    ST_ADD_REQ,
    ST_ADD_WAIT,
    ST_DONE
  } state_e;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Curve field prime and generator, used by benches
  localparam logic [255:0] SECP256K1_P  =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] SECP256K1_GX =
    256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] SECP256K1_GY =
    256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;

endpackage

// File: rtl/ecc_scalar_scan.sv
// Scalar shift register and bit-index counter; presents bits MSB first.
module ecc_scalar_scan #(
  parameter int unsigned KW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [KW-1:0] k_i,
  input  logic          advance_i,
  output logic          bit_o,
  output logic          is_last_o
);

  localparam int unsigned IW = (KW > 1) ? $clog2(KW) : 1;

  logic [KW-1:0] k_q, k_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    k_d   = k_q;
    idx_d = idx_q;
    if (load_i) begin
      k_d   = k_i;
      idx_d = IW'(KW - 1);
    end else if (advance_i) begin
      k_d   = k_q << 1;
      idx_d = idx_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q   <= '0;
      idx_q <= '0;
    end else begin
      k_q   <= k_d;
      idx_q <= idx_d;
    end
  end

  assign bit_o     = k_q[KW-1];
  assign is_last_o = (idx_q == '0);

endmodule

// File: rtl/ecc_scalar_mult_ctrl.sv
// MSB-first double-and-add sequencer for Q = k*P over a shared point-op unit.
// Define ECC_SCALAR_MULT_CTRL_CONST_TIME_EN for a fixed double+add per scalar bit.
module ecc_scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned KW = KW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [W-1:0]  x1,
  input  logic [W-1:0]  y1,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  x_output,
  output logic [W-1:0]  y_output,
  output logic          out_inf,
  output logic          op_valid,
  input  logic          op_ready,
  output logic          op_sel,
  output logic [W-1:0]  op_ax,
  output logic [W-1:0]  op_ay,
  output logic [W-1:0]  op_bx,
  output logic [W-1:0]  op_by,
  input  logic          res_valid,
  input  logic [W-1:0]  res_x,
  input  logic [W-1:0]  res_y,
  input  logic          res_inf
);

  state_e         state_q, state_d;
  logic [W-1:0]   px_q, px_d, py_q, py_d;
  logic [W-1:0]   acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic           acc_inf_q, acc_inf_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [W-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
  logic           inf_out_q, inf_out_d;
  logic           op_valid_q, op_valid_d, op_sel_q, op_sel_d;
  logic [W-1:0]   op_ax_q, op_ax_d, op_ay_q, op_ay_d;
  logic [W-1:0]   op_bx_q, op_bx_d, op_by_q, op_by_d;

  logic scan_load, scan_adv, scan_bit, scan_last, do_next;

  ecc_scalar_scan #(.KW(KW)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .load_i   (scan_load),
    .k_i      (k),
    .advance_i(scan_adv),
    .bit_o    (scan_bit),
    .is_last_o(scan_last)
  );

  assign scan_adv = do_next & ~scan_last;

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    acc_inf_d  = acc_inf_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    inf_out_d  = inf_out_q;
    op_sel_d   = op_sel_q;
    op_ax_d    = op_ax_q;
    op_ay_d    = op_ay_q;
    op_bx_d    = op_bx_q;
    op_by_d    = op_by_q;
    scan_load  = 1'b0;
    do_next    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scan_load = 1'b1;
          px_d      = x1;
          py_d      = y1;
          acc_x_d   = '0;
          acc_y_d   = '0;
          acc_inf_d = 1'b1;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
`ifdef ECC_SCALAR_MULT_CTRL_CONST_TIME_EN
        state_d = ST_DBL_REQ;
`else
        // Leading zeros cost nothing; the first set bit just loads P
        if (acc_inf_q) begin
          if (scan_bit) begin
            acc_x_d   = px_q;
            acc_y_d   = py_q;
            acc_inf_d = 1'b0;
          end
          do_next = 1'b1;
        end else begin
          state_d = ST_DBL_REQ;
        end
`endif
      end
      ST_DBL_REQ: begin
        if (op_ready) state_d = ST_DBL_WAIT;
      end
      ST_DBL_WAIT: begin
        if (res_valid) begin
`ifdef ECC_SCALAR_MULT_CTRL_CONST_TIME_EN
          if (!acc_inf_q) begin
            acc_x_d   = res_x;
            acc_y_d   = res_y;
            acc_inf_d = res_inf;
          end
          state_d = ST_ADD_REQ;
`else
          acc_x_d   = res_x;
          acc_y_d   = res_y;
          acc_inf_d = res_inf;
          if (!scan_bit) begin
            do_next = 1'b1;
          end else if (res_inf) begin
            acc_x_d   = px_q;
            acc_y_d   = py_q;
            acc_inf_d = 1'b0;
            do_next   = 1'b1;
          end else begin
            state_d = ST_ADD_REQ;
          end
`endif
        end
      end
      ST_ADD_REQ: begin
        if (op_ready) state_d = ST_ADD_WAIT;
      end
      ST_ADD_WAIT: begin
        if (res_valid) begin
`ifdef ECC_SCALAR_MULT_CTRL_CONST_TIME_EN
          if (scan_bit && acc_inf_q) begin
            acc_x_d   = px_q;
            acc_y_d   = py_q;
            acc_inf_d = 1'b0;
          end else if (scan_bit) begin
            acc_x_d   = res_x;
            acc_y_d   = res_y;
            acc_inf_d = res_inf;
          end
`else
          acc_x_d   = res_x;
          acc_y_d   = res_y;
          acc_inf_d = res_inf;
`endif
          do_next = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_next) state_d = scan_last ? ST_DONE : ST_SCAN;

    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    op_valid_d = (state_d == ST_DBL_REQ) || (state_d == ST_ADD_REQ);

    // Operands load once on request entry and hold through any op_ready stall
    if (op_valid_d && (state_d != state_q)) begin
      op_sel_d = (state_d == ST_ADD_REQ) ? OP_ADD : OP_DBL;
      op_ax_d  = acc_inf_d ? px_q : acc_x_d;
      op_ay_d  = acc_inf_d ? py_q : acc_y_d;
      op_bx_d  = px_q;
      op_by_d  = py_q;
    end

    if (done_d) begin
      x_out_d   = acc_inf_d ? '0 : acc_x_d;
      y_out_d   = acc_inf_d ? '0 : acc_y_d;
      inf_out_d = acc_inf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      px_q       <= '0;
      py_q       <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      acc_inf_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      inf_out_q  <= 1'b0;
      op_valid_q <= 1'b0;
      op_sel_q   <= 1'b0;
      op_ax_q    <= '0;
      op_ay_q    <= '0;
      op_bx_q    <= '0;
      op_by_q    <= '0;
    end else begin
      state_q    <= state_d;
      px_q       <= px_d;
      py_q       <= py_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      acc_inf_q  <= acc_inf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      inf_out_q  <= inf_out_d;
      op_valid_q <= op_valid_d;
      op_sel_q   <= op_sel_d;
      op_ax_q    <= op_ax_d;
      op_ay_q    <= op_ay_d;
      op_bx_q    <= op_bx_d;
      op_by_q    <= op_by_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign x_output = x_out_q;
  assign y_output = y_out_q;
  assign out_inf  = inf_out_q;
  assign op_valid = op_valid_q;
  assign op_sel   = op_sel_q;
  assign op_ax    = op_ax_q;
  assign op_ay    = op_ay_q;
  assign op_bx    = op_bx_q;
  assign op_by    = op_by_q;

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Scoreboard bench for ecc_scalar_mult_ctrl with a tagged point-op model:
// a point with tag t is (t, ~t); double gives 2t, add gives ta+tb, tag 0 is infinity.
module tb_ecc_scalar_mult_ctrl;
  import ecc_pkg::*;

  localparam int unsigned W  = 256;
  localparam int unsigned KW = 256;
  localparam int LAT_DEF = 2;

`ifdef ECC_SCALAR_MULT_CTRL_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  logic          clk, reset, start;
  logic [KW-1:0] k;
  logic [W-1:0]  x1, y1;
  logic          busy, done, out_inf, op_valid, op_ready, op_sel;
  logic [W-1:0]  x_output, y_output, op_ax, op_ay, op_bx, op_by;
  logic          res_valid, res_inf;
  logic [W-1:0]  res_x, res_y;

  ecc_scalar_mult_ctrl #(.W(W), .KW(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .x1(x1), .y1(y1),
    .busy(busy), .done(done), .x_output(x_output), .y_output(y_output),
    .out_inf(out_inf), .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
    .op_ax(op_ax), .op_ay(op_ay), .op_bx(op_bx), .op_by(op_by),
    .res_valid(res_valid), .res_x(res_x), .res_y(res_y), .res_inf(res_inf)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         inf;
    int           ops;
    int           lat;
    logic [4:0]   sel;
    int           seln;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   ops_base = 0;
  int   ops_cnt = 0;
  int   add_cnt = 0;
  int   done_cnt = 0;
  int   stall = 0;
  int   lat = LAT_DEF;
  logic [4:0] sel_hist = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Point-op unit model: stalls op_ready, checks operand stability, returns tagged result
  initial begin : op_model
    logic         hs, tracking;
    logic [W-1:0] rx;
    logic [W-1:0] s_ax, s_ay, s_bx, s_by;
    logic         s_sel;
    int           waited, pend;
    op_ready = 1'b0; res_valid = 1'b0; res_x = '0; res_y = '0; res_inf = 1'b0;
    tracking = 1'b0; waited = 0; pend = 0; rx = '0;
    s_ax = '0; s_ay = '0; s_bx = '0; s_by = '0; s_sel = 1'b0;
    forever begin
      @(posedge clk);
      hs = reset && op_valid && op_ready;
      if (hs) begin
        rx = op_sel ? (op_ax + op_bx) : (op_ax << 1);
        ops_cnt++;
        if (op_sel) add_cnt++;
        sel_hist = {sel_hist[3:0], op_sel};
        pend = lat;
      end
      #1;
      res_valid = 1'b0;
      if (hs || !reset) begin
        op_ready = 1'b0;
        tracking = 1'b0;
        waited   = 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          res_valid = 1'b1;
          res_x     = rx;
          res_y     = ~rx;
          res_inf   = (rx == '0);
        end
      end
      if (reset && op_valid && !op_ready) begin
        if (!tracking) begin
          s_sel = op_sel; s_ax = op_ax; s_ay = op_ay; s_bx = op_bx; s_by = op_by;
          tracking = 1'b1;
        end else begin
          chk("stall_stable", {op_sel, op_ax, op_ay, op_bx, op_by} == {s_sel, s_ax, s_ay, s_bx, s_by} ? W'(1) : W'(0), W'(1));
        end
        if (waited >= stall) op_ready = 1'b1;
        else waited++;
      end
    end
  end

  // Monitor: pops an expectation on every done pulse
  initial begin : monitor
    exp_t e;
    logic post;
    int unsigned m;
    post = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (post) begin
        chk("post_done_idle", W'({busy, done}), W'(0));
        post = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", W'(1), W'(0));
        end else begin
          e = exp_q.pop_front();
          chk("x_output", x_output, e.x);
          chk("y_output", y_output, e.y);
          chk("out_inf", W'(out_inf), W'(e.inf));
          chk("busy_at_done", W'(busy), W'(1));
          chk("op_count", W'(ops_cnt - ops_base), W'(e.ops));
          if (e.lat != 0) chk("done_cycle", W'(cyc - start_cyc + 1), W'(e.lat));
          if (e.seln != 0) begin
            m = (32'd1 << e.seln) - 32'd1;
            chk("op_sel_seq", W'(sel_hist & 5'(m)), W'(e.sel & 5'(m)));
          end
        end
        post = 1'b1;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [KW-1:0] kk, input logic [W-1:0] px, input logic [W-1:0] py,
                       input logic push, input exp_t e);
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk);
      #2;
    end
    ops_base = ops_cnt;
    k = kk; x1 = px; y1 = py; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start_cyc = cyc;
    if (push) exp_q.push_back(e);
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (done_cnt == base) begin
      chk("done_timeout", W'(1), W'(0));
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [KW-1:0] kk, input logic [W-1:0] px, input logic [W-1:0] py,
                     input logic [W-1:0] ex, input logic [W-1:0] ey, input logic einf,
                     input int eops, input int elat, input logic [4:0] esel, input int eseln);
    exp_t e;
    int base;
    e.x = ex; e.y = ey; e.inf = einf; e.ops = eops; e.lat = elat; e.sel = esel; e.seln = eseln;
    base = done_cnt;
    issue(kk, px, py, 1'b1, e);
    wait_done(base);
  endtask

  initial begin : stim
    logic [W-1:0] one, ones, msb;
    exp_t none;
    int n, abase;
    one  = W'(1);
    ones = '1;
    msb  = one << (W - 1);
    none.x = '0; none.y = '0; none.inf = 1'b0; none.ops = 0; none.lat = 0; none.sel = '0; none.seln = 0;
    reset = 1'b0; start = 1'b0; k = '0; x1 = '0; y1 = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_op_valid", W'(op_valid), W'(0));
    chk("rst_op_sel", W'(op_sel), W'(0));
    chk("rst_out_inf", W'(out_inf), W'(0));
    chk("rst_x_output", x_output, W'(0));
    chk("rst_op_ax", op_ax, W'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // k=0 on G: infinity, no ops, done in cycle T0+257
    run(KW'(0), SECP256K1_GX, SECP256K1_GY, '0, '0, 1'b1,
        CT ? 512 : 0, CT ? 0 : 257, 5'b10101, CT ? 5 : 0);
    // k=1 on (5,7)
    run(KW'(1), W'(5), W'(7), W'(5), W'(7), 1'b0,
        CT ? 512 : 0, CT ? 0 : 257, 5'b10101, CT ? 5 : 0);
    // k=11: dbl, dbl, add, dbl, add
    run(KW'(11), one, ~one, W'(11), ~W'(11), 1'b0,
        CT ? 512 : 5, 0, CT ? 5'b10101 : 5'b00101, 5);
    // Same with 5-cycle op_ready stall on every request
    stall = 5;
    run(KW'(11), one, ~one, W'(11), ~W'(11), 1'b0,
        CT ? 512 : 5, 0, CT ? 5'b10101 : 5'b00101, 5);
    stall = 0;
    // Only the MSB set: 255 doubles after loading P
    run(KW'(msb), one, ~one, msb, ~msb, 1'b0,
        CT ? 512 : 255, 0, CT ? 5'b10101 : 5'b00000, 5);
    // All ones: (2^256-1)*P
    run(KW'(ones), one, ~one, ones, '0, 1'b0,
        CT ? 512 : 510, 0, 5'b10101, 5);

    // Abort k=0x0F inside the first ADD_WAIT; the late result lands while idle
    lat = 6;
    abase = add_cnt;
    issue(KW'(15), one, ~one, 1'b0, none);
    n = 0;
    while (add_cnt == abase && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (add_cnt == abase) chk("add_timeout", W'(1), W'(0));
    reset = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_op_valid", W'(op_valid), W'(0));
    chk("abort_x_output", x_output, W'(0));
    chk("abort_y_output", y_output, W'(0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    lat = LAT_DEF;
    repeat (8) @(posedge clk);
    #1;
    chk("late_res_idle", W'({busy, op_valid}), W'(0));
    run(KW'(2), one, ~one, W'(2), ~W'(2), 1'b0,
        CT ? 512 : 1, 0, CT ? 5'b10101 : 5'b00000, CT ? 5 : 1);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
# ecc_scalar_mult_ctrl

Sequencer for secp256k1 scalar multiplication, Q = k·P, using MSB-first double-and-add. It owns the scalar, the accumulator point and the bit index. It issues point-double and point-add requests to one shared external point-operation unit over a valid/ready handshake. The block sits between the scalar-multiply top level and the point-op datapath and replaces ad-hoc sequencing in the top.

## Interface
- `W`, 256, coordinate width
- `KW`, 256, scalar width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `start` in 1: request a multiply; sampled only in IDLE
- `k` in KW: scalar, latched on start
- `x1`, `y1` in W each: base point P, latched on start
- `busy` out 1: high from the start-accept edge until done
- `done` out 1: one-cycle pulse when the result is valid
- `x_output`, `y_output` out W each: result Q, held until the next start
- `out_inf` out 1: Q is the point at infinity
- `op_valid` out 1: point-op request
- `op_ready` in 1: unit accepts the request
- `op_sel` out 1: 0 = double(A), 1 = add(A,B)
- `op_ax`, `op_ay`, `op_bx`, `op_by` out W each: operands A and B
- `res_valid` in 1: one-cycle result strobe
- `res_x`, `res_y` in W each: result coordinates
- `res_inf` in 1: result is infinity

## Operation
- States: IDLE, SCAN, DBL_REQ, DBL_WAIT, ADD_REQ, ADD_WAIT, DONE.
- IDLE:
  - On start, latch k and P; set idx = KW-1, acc_inf = 1; go to SCAN.
  - start is ignored in every other state.
- SCAN, handling bit k[idx]:
  - acc_inf=1 and bit=0: no operation, go to NEXT.
  - acc_inf=1 and bit=1: acc = P, acc_inf = 0, go to NEXT.
  - acc_inf=0: go to DBL_REQ.
- DBL_REQ:
  - op_sel=0, A=acc. Hold until op_ready.
  - Then go to DBL_WAIT. On res_valid: acc = res, acc_inf = res_inf.
  - If bit=1, go to ADD_REQ; otherwise go to NEXT.
- ADD_REQ:
  - op_sel=1, A=acc, B=P. Same handshake; result captured in ADD_WAIT.
  - If acc_inf=1 after the double, skip the add: acc = P, acc_inf = 0.
- NEXT: if idx==0 go to DONE; otherwise idx−1 and go to SCAN.
- DONE:
  - x_output/y_output/out_inf = acc/acc_inf.
  - done=1 for one cycle, then go to IDLE.
  - If acc_inf, coordinates are driven to 0.
- Handshake rules:
  - op_valid, op_sel and all operands stay stable while op_valid=1 and op_ready=0.
  - One request is outstanding at a time.
  - res_valid outside the WAIT states is ignored; it is a bench assertion error.
- k=0 gives out_inf=1 with zero ops. k=1 gives Q=P with zero ops.

## Timing
- Reset values:
  - State IDLE.
  - busy, done, op_valid, op_sel, out_inf all 0.
  - All data outputs 0.
- Start-accept at edge T0: busy=1 after T0; first SCAN cycle is T0+1.
- Each SCAN takes 1 cycle.
- A request costs 1 cycle minimum in REQ, plus op_ready wait, plus result latency.
- Default build, no ops (k=0 or k=1): done is high in cycle T0+KW+1 (257). busy drops the same edge done drops.
- Reset asserted mid-operation:
  - Immediately IDLE, op_valid=0, outputs cleared.
  - A late res_valid after reset is ignored.

## Configuration
- `ECC_SCALAR_MULT_CTRL_CONST_TIME_EN` defined:
  - Every bit issues exactly one double then one add, giving 2·KW ops for every k, including leading zeros.
  - While acc_inf, dummy ops use A=P; results are discarded.
  - An add result is kept only if bit=1 and acc_inf=0 before the add. If acc_inf=1 and bit=1, acc = P.
- Undefined: leading-zero skipping and add-skip on 0 bits, as in Operation.

## Structure
- Shared package `ecc_pkg`:
  - state enum.
  - OP_DBL/OP_ADD encodings.
  - W/KW defaults.
  - secp256k1 p and G constants for benches.
- Sub-module `ecc_scalar_scan`: holds the scalar shift register and idx counter, and provides bit, is_last and advance.
- Controller FSM and the accumulator stay in the top.

## Test plan
- k=0, P=G, default build, point-op model: out_inf=1, zero op_valid pulses, done at cycle 257 after start.
- k=1, P=(0x5,0x7): x_output=0x5, y_output=0x7, out_inf=0, zero ops.
- k=11 (0b1011): op_sel sequence 0,0,1,0,1. With a tagged-op model, final acc equals the model's 11·P tag.
- k=11, op_ready held low 5 cycles on each request: operands and op_sel stable throughout; result unchanged.
- k=0x0F, reset pulled low during ADD_WAIT, then start with k=2: busy=0 and op_valid=0 immediately. The second run issues exactly one double; result is 2·P.
- CONST_TIME_EN, k=0 and k=all-ones: both issue exactly 512 ops. Results are infinity and the model's (2^256−1)·P respectively.
